// File: rtl/mux8_arb_pkg.sv
// Shared types and helpers for the eight-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot_from_sel(input sel_t s);
    logic [NUM_REQ-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder: first set req bit searching from last+1 upward, modulo 8.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               last,
  output logic               found,
  output sel_t               idx
);

  sel_t cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      // i+1 wraps to 0 on the final pass, so the previous winner is tried last
      cand = last + sel_t'(i + 1);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the registered select of an 8:1 mux.
// Optional grant timeout enabled by defining MUX8_ARB_TIMEOUT_EN.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output sel_t               sel,
  output logic               busy,
  output logic               preempt
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must lie in 2..255");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  sel_t               sel_q, sel_d;
  sel_t               last_q, last_d;
  logic               busy_q, busy_d;
  logic               preempt_q, preempt_d;
  logic               take;

  logic [NUM_REQ-1:0] pick_req;
  logic               pick_found;
  sel_t               pick_idx;

  // Masking the current holder lets the same picker serve release and preemption.
  assign pick_req = req & ~grant_q;

  rr_pick8 u_pick (
    .req   (pick_req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       expired;

  assign expired = (cnt_q == HoldLast);

  always_comb begin
    cnt_d = cnt_q;
    if (take) begin
      cnt_d = '0;
    end else if (state_q == ARB_GRANT && !expired) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic expired;
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    preempt_d = 1'b0;
    take      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          take = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (!req[sel_q]) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end else if (expired && pick_found) begin
          take      = 1'b1;
          preempt_d = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
    if (take) begin
      state_d = ARB_GRANT;
      grant_d = onehot_from_sel(pick_idx);
      sel_d   = pick_idx;
      last_d  = pick_idx;
    end
    busy_d = (state_d == ARB_GRANT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      last_q    <= sel_t'(NUM_REQ - 1);
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter with hand-computed expectations.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  int n_checks;
  int n_errors;

  mux8_rr_arbiter #(
    .HOLD_MAX (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                            input logic b, input logic p);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".preempt"}, 32'(preempt), 32'(p));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    req = 8'h00;

    // Reset held two cycles with no requests
    tick();
    expect_out("rst0", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    expect_out("rst1", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single request: grant only after the edge, then release to idle
    req = 8'h10;
    #1;
    check("nocomb.grant", 32'(grant), 32'h0);
    tick();
    expect_out("single", 8'h10, 3'd4, 1'b1, 1'b0);
    tick();
    expect_out("single_hold", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    expect_out("single_rel", 8'h00, 3'd4, 1'b0, 1'b0);
    tick();
    expect_out("single_idle", 8'h00, 3'd4, 1'b0, 1'b0);

    // Full rotation: every grantee holds 3 cycles, drops for one, re-raises
    do_reset();
    req = 8'hFF;
    tick();
    expect_out("rot_first", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] cur;
      logic [2:0] nxt;
      logic [7:0] nxt_oh;
      cur    = 3'(k - 1);
      nxt    = 3'(k);
      nxt_oh = 8'h01 << nxt;
      tick();
      tick();
      check($sformatf("rot_hold%0d", k), 32'(sel), 32'(cur));
      req[cur] = 1'b0;
      tick();
      req[cur] = 1'b1;
      expect_out($sformatf("rot%0d", k), nxt_oh, nxt, 1'b1, 1'b0);
    end
    req = 8'h00;
    tick();
    tick();
    expect_out("rot_end", 8'h00, 3'd0, 1'b0, 1'b0);

    // Wrap fairness between bits 6 and 0
    do_reset();
    req = 8'h40;
    tick();
    expect_out("wrap_g6", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h41;
    tick();
    expect_out("wrap_late", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h01;
    tick();
    expect_out("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h41;
    tick();
    expect_out("wrap_g0hold", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h40;
    tick();
    expect_out("wrap_g6b", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    expect_out("wrap_idle", 8'h00, 3'd6, 1'b0, 1'b0);

    // Mid-tenure reset restores bit-0 priority
    do_reset();
    req = 8'h08;
    tick();
    expect_out("mrst_g3", 8'h08, 3'd3, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("mrst_drop", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h09;
    tick();
    expect_out("mrst_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h08;
    tick();
    expect_out("mrst_g3b", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    tick();

    // Bit 2 holds while bit 5 waits
    do_reset();
    req = 8'h04;
    tick();
    expect_out("to_g2", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h24;
    for (int c = 1; c <= 3; c++) begin
      tick();
      expect_out($sformatf("to_wait%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    tick();
`ifdef MUX8_ARB_TIMEOUT_EN
    expect_out("to_pre", 8'h20, 3'd5, 1'b1, 1'b1);
    tick();
    expect_out("to_after", 8'h20, 3'd5, 1'b1, 1'b0);
`else
    expect_out("to_nopre", 8'h04, 3'd2, 1'b1, 1'b0);
    tick();
    expect_out("to_nopre2", 8'h04, 3'd2, 1'b1, 1'b0);
`endif

    // Bit 2 alone is never preempted
    do_reset();
    req = 8'h04;
    for (int c = 0; c < 8; c++) begin
      tick();
      expect_out($sformatf("alone%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    req = 8'h00;
    tick();
    expect_out("alone_rel", 8'h00, 3'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares the 8:1 selector datapath between eight requesters. It produces the registered 3-bit select for the mux and a one-hot grant vector, so exactly one requester's data reaches the mux output at a time. It sits directly upstream of the mux select input and replaces any static select wiring.

Parameters:
NUM_REQ, 8, number of requesters; fixed at 8 to match the mux width.
SEL_W, 3, select width; must equal log2(NUM_REQ).
HOLD_MAX, 16, maximum grant tenure in cycles; used only with the optional feature; legal range 2..255.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req  input  8  request vector; bit i requests mux data input i; level-held for the whole tenure.
grant  output  8  one-hot registered grant; bit i matches mux data input i; all-zero when idle.
sel  output  3  registered mux select; equals the index of the set grant bit; holds its last value when idle.
busy  output  1  high while any grant is asserted.
preempt  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without the optional feature.

Behaviour:
- Reset (rst=1 at a clock edge):
  - grant=0, sel=0, busy=0, preempt=0.
  - Round-robin pointer last=7, so requester 0 has top priority after reset.
  - State=IDLE. Reset overrides every other event, including mid-tenure; the grant drops on the next edge.
- State IDLE:
  - If req!=0 at an edge, pick the first set bit searching last+1, last+2, ... with modulo-8 wrap.
  - Register grant, sel, last and busy, then go to GRANT.
  - Latency: req sampled at edge N gives grant visible after edge N. Minimum latency is 1 cycle.
- State GRANT:
  - Tenure continues while req[sel]=1.
  - If req[sel]=0 at an edge and another req bit is set, re-arbitrate in that same edge. The next winner is granted with no idle gap (back-to-back handover).
  - If req[sel]=0 at an edge and req==0, clear grant and busy and go to IDLE. sel holds its value.
- Fairness:
  - last updates only on a new grant.
  - The winner's own bit has lowest priority in the next arbitration.
  - Any continuously asserted requester is served within 7 tenures.
- Boundary conditions:
  - Wrap: last=7 searches from bit 0.
  - A requester dropping and re-raising within one cycle is a new request and goes to the back of the round-robin order.
  - req bits rising during a tenure have no effect until the release edge.
  - All 8 requesting: grants rotate 0,1,...,7,0 as each releases.
- Invariants: grant is always one-hot or zero; grant==(1<<sel) whenever busy=1.
- Outputs are registered only, with no combinational path from req to grant or sel.

Optional Feature:
Macro MUX8_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit tenure counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches HOLD_MAX-1 and another req bit is set, the current grant is revoked at the next edge and the next round-robin winner is granted in that edge. preempt pulses for one cycle, aligned with the new grant.
  - If no other requester is pending, the tenure continues and the counter saturates.
- Not defined: no counter is built, tenure is unlimited, and preempt is tied to 0.

Decomposition:
- Shared package mux8_arb_pkg:
  - Constants NUM_REQ=8 and SEL_W=3.
  - State enum {ARB_IDLE, ARB_GRANT}.
  - sel_t typedef (3-bit).
  - Helper function onehot_from_sel.
- One sub-module, rr_pick8: a purely combinational rotating priority encoder.
  - Inputs: req[7:0], last[2:0].
  - Outputs: found, idx[2:0].
  - Instantiated once by the arbiter FSM.

Test Plan:
- Reset then idle: rst held 2 cycles with req=0 -> grant=0, sel=0, busy=0 and preempt=0 every cycle.
- Single request: req=8'h10 at edge N -> grant=8'h10 and sel=4 after edge N. Drop req -> grant=0 and busy=0 next edge, sel stays 4.
- Full rotation: req=8'hFF, each grantee holds 3 cycles then drops for 1 cycle -> sel sequence 0,1,2,3,4,5,6,7,0 with no idle cycle between grants.
- Wrap fairness: grant 6 active and req=8'h41 (bits 6 and 0); drop bit 6 -> next grant is bit 0. Re-raise bit 6 -> bit 6 is served after bit 0 releases.
- Mid-tenure reset: grant 3 active and rst=1 for one cycle -> grant=0, busy=0 next edge. With req=8'h09 afterwards, bit 0 wins first.
- Timeout (MUX8_ARB_TIMEOUT_EN, HOLD_MAX=4):
  - Bit 2 holds and bit 5 requests -> grant moves to bit 5 exactly 4 cycles after bit 2's grant, with a single preempt pulse.
  - Bit 2 held alone -> no preemption.
